// File: rtl/frodo_mul_seq_if.sv
// Job, operand-beat and result bundle for frodo_mul_seq.
// master = job issuer / operand source / result sink, slave = the multiplier.
interface frodo_mul_seq_if #(
  parameter int unsigned A  = 4,
  parameter int unsigned S  = 8,
  parameter int unsigned SW = 5
);
  logic                  start;
  logic                  isMatrixMul1;
  logic                  isPos;
  logic [15:0]           len;
  logic [16*S-1:0]       accVec;
  logic [SW*S-1:0]       sCol;
  logic [SW*A*S-1:0]     sMat;
  logic [16*A*S-1:0]     accMat;
  logic [16*A-1:0]       a;
  logic                  a_valid;
  logic                  a_ready;
  logic [16*S-1:0]       outVec;
  logic [16*A*S-1:0]     outMat;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  err;

  modport master (
    output start, isMatrixMul1, isPos, len, accVec, sCol, sMat, accMat, a, a_valid, out_ready,
    input  a_ready, outVec, outMat, out_valid, busy, err
  );

  modport slave (
    input  start, isMatrixMul1, isPos, len, accVec, sCol, sMat, accMat, a, a_valid, out_ready,
    output a_ready, outVec, outMat, out_valid, busy, err
  );
endinterface

// File: rtl/frodo_mul_seq.sv
// Sequential FrodoKEM-style secret multiplier.
// Mode1 accumulates sum_i s[j][i]*a_i into a per-row vector over len beats.
// Mode2 streams one A x S matrix result per beat: accMat + s_j*a_i.
// Products are shift-and-add of the secret magnitude, sign-applied, mod 2^16,
// with result bits 15..QB cleared.
// Optional secret range check: define FRODO_MUL_SEQ_SCHECK_EN.
module frodo_mul_seq #(
  parameter int unsigned A    = 4,
  parameter int unsigned S    = 8,
  parameter int unsigned SW   = 5,
  parameter int unsigned QB   = 16,
  parameter int unsigned SMAX = 12
) (
  input logic            clk,
  input logic            rst,
  frodo_mul_seq_if.slave bus
);

  localparam logic [15:0] QMask = 16'((32'd1 << QB) - 32'd1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              r_st, w_st_next;
  logic                r_mode1, r_pos, r_out_valid;
  logic [15:0]         r_len, r_cnt;
  logic [SW*S-1:0]     r_scol;
  logic [16*S-1:0]     r_acc;
  logic [16*A*S-1:0]   r_outmat;

  logic                w_start, w_a_ready, w_accept, w_last, w_consume;
  logic [16*S-1:0]     w_acc_init, w_acc_next;
  logic [16*A*S-1:0]   w_mat_next;

  // Magnitude bits SW-1..1 weigh 1,2,4,...; negate when sign XOR subtract-mode.
  function automatic logic [15:0] f_prod(input logic [SW-1:0] s, input logic [15:0] av,
                                         input logic pos);
    logic [15:0] sum;
    sum = '0;
    for (int k = 1; k < SW; k++) begin
      if (s[k]) sum = sum + (av << (k - 1));
    end
    return (s[0] ^ ~pos) ? (~sum + 16'd1) : sum;
  endfunction

  assign w_start   = (r_st == StIdle) & bus.start;
  // Mode2 output register is one deep: a new beat only when it is free or draining.
  assign w_a_ready = (r_st == StRun) & (r_mode1 | ~r_out_valid | bus.out_ready);
  assign w_accept  = bus.a_valid & w_a_ready;
  assign w_last    = (r_cnt + 16'd1) == r_len;
  assign w_consume = r_out_valid & bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_st <= StIdle;
    else     r_st <= w_st_next;
  end

  // Next-state decode.
  always_comb begin
    w_st_next = r_st;
    unique case (r_st)
      StIdle: if (bus.start) w_st_next = (bus.len == 16'd0) ? StDone : StRun;
      StRun:  if (w_accept && w_last) w_st_next = StDone;
      // Mode2 with len=0 never produces a result, so leave when nothing is pending.
      StDone: if (w_consume || !r_out_valid) w_st_next = StIdle;
      default: w_st_next = StIdle;
    endcase
  end

  // Per-row beat sums for mode1 and per-element results for mode2.
  always_comb begin
    logic [15:0] v_row;
    v_row      = '0;
    w_acc_init = '0;
    w_acc_next = '0;
    w_mat_next = '0;
    for (int j = 0; j < S; j++) begin
      w_acc_init[16*j +: 16] = bus.accVec[16*j +: 16] & QMask;
      v_row = r_acc[16*j +: 16];
      for (int i = 0; i < A; i++) begin
        v_row = v_row + f_prod(bus.sMat[(j*A+i)*SW +: SW], bus.a[16*i +: 16], r_pos);
        w_mat_next[16*(j*A+i) +: 16] =
          (bus.accMat[16*(j*A+i) +: 16] + f_prod(r_scol[SW*j +: SW], bus.a[16*i +: 16], r_pos))
          & QMask;
      end
      w_acc_next[16*j +: 16] = v_row & QMask;
    end
  end

  // Job latches, beat counter, accumulator and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode1     <= 1'b0;
      r_pos       <= 1'b0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_scol      <= '0;
      r_acc       <= '0;
      r_outmat    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_start) begin
      r_mode1     <= bus.isMatrixMul1;
      r_pos       <= bus.isPos;
      r_len       <= bus.len;
      r_cnt       <= '0;
      if (bus.isMatrixMul1) r_acc  <= w_acc_init;
      else                  r_scol <= bus.sCol;
      // Mode1 with len=0 presents accVec immediately.
      r_out_valid <= bus.isMatrixMul1 & (bus.len == 16'd0);
    end else if (w_accept) begin
      r_cnt <= r_cnt + 16'd1;
      if (r_mode1) begin
        r_acc       <= w_acc_next;
        r_out_valid <= w_last;
      end else begin
        r_outmat    <= w_mat_next;
        r_out_valid <= 1'b1;
      end
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.a_ready   = w_a_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_st != StIdle);
  assign bus.outVec    = r_acc;
  assign bus.outMat    = r_outmat;

`ifdef FRODO_MUL_SEQ_SCHECK_EN
  logic r_err;
  logic w_bad_start, w_bad_beat;

  // Flag any out-of-range secret magnitude on the sCol/sMat the job actually uses.
  always_comb begin
    w_bad_start = 1'b0;
    w_bad_beat  = 1'b0;
    for (int j = 0; j < S; j++) begin
      if (32'(bus.sCol[SW*j+1 +: SW-1]) > SMAX) w_bad_start = 1'b1;
      for (int i = 0; i < A; i++) begin
        if (32'(bus.sMat[(j*A+i)*SW+1 +: SW-1]) > SMAX) w_bad_beat = 1'b1;
      end
    end
  end

  // Sticky error, re-evaluated at each start.
  always_ff @(posedge clk) begin
    if (rst)                                r_err <= 1'b0;
    else if (w_start)                       r_err <= ~bus.isMatrixMul1 & w_bad_start;
    else if (w_accept & r_mode1 & w_bad_beat) r_err <= 1'b1;
  end

  assign bus.err = r_err;
`else
  logic w_unused_smax;
  assign w_unused_smax = ^SMAX;
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_frodo_mul_seq.sv
// Randomized scoreboard bench for frodo_mul_seq with an arithmetic reference model.
module tb_frodo_mul_seq;
  localparam int unsigned A    = 4;
  localparam int unsigned S    = 8;
  localparam int unsigned SW   = 5;
  localparam int unsigned QB   = 16;
  localparam int unsigned SMAX = 12;
  localparam int unsigned MB   = SW - 1;
  localparam int VW = 16 * S;
  localparam int MW = 16 * A * S;
  localparam longint M = longint'(1) << QB;

  typedef struct {
    bit            m1;
    logic [VW-1:0] vec;
    logic [MW-1:0] mat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rdy_rand = 0;
  bit   rdy_force = 0;
  exp_t sb[$];

  frodo_mul_seq_if #(.A(A), .S(S), .SW(SW)) bus ();

  frodo_mul_seq #(.A(A), .S(S), .SW(SW), .QB(QB), .SMAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, want bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, MW'(act), MW'(exp));
  endtask

  function automatic longint md(input longint x);
    longint r;
    r = x % M;
    if (r < 0) r += M;
    return r;
  endfunction

  // Signed secret value: +/- magnitude, flipped for subtract mode.
  function automatic longint sval(input logic [SW-1:0] s, input bit pos);
    longint m;
    m = longint'(s[SW-1:1]);
    return (s[0] ^ !pos) ? -m : m;
  endfunction

  function automatic logic [SW-1:0] rand_s();
    logic [SW-1:0] s;
    s[SW-1:1] = MB'($urandom_range(0, SMAX));
    s[0]      = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic logic [16*A-1:0] rand_a();
    logic [16*A-1:0] v;
    for (int i = 0; i < A; i++) v[16*i +: 16] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [SW*A*S-1:0] rand_smat();
    logic [SW*A*S-1:0] v;
    for (int k = 0; k < A*S; k++) v[k*SW +: SW] = rand_s();
    return v;
  endfunction

  function automatic logic [SW*S-1:0] rand_scol();
    logic [SW*S-1:0] v;
    for (int k = 0; k < S; k++) v[k*SW +: SW] = rand_s();
    return v;
  endfunction

  function automatic logic [MW-1:0] rand_amat();
    logic [MW-1:0] v;
    for (int k = 0; k < A*S; k++) v[16*k +: 16] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < S; k++) v[16*k +: 16] = 16'($urandom);
    return v;
  endfunction

  // Sole driver of out_ready: random back-pressure or a forced level.
  initial begin
    bus.out_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: pops and compares on each result handshake, and checks hold behaviour.
  initial begin
    bit            hold_pend;
    logic [VW-1:0] prev_vec;
    logic [MW-1:0] prev_mat;
    exp_t          e;
    hold_pend = 0;
    prev_vec  = '0;
    prev_mat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 0;
      end else begin
        if (hold_pend) begin
          chk1("hold_valid", bus.out_valid, 1'b1);
          chk("hold_outVec", MW'(bus.outVec), MW'(prev_vec));
          chk("hold_outMat", bus.outMat, prev_mat);
        end
        hold_pend = bus.out_valid & ~bus.out_ready;
        prev_vec  = bus.outVec;
        prev_mat  = bus.outMat;
        if (hold_pend) chk1("stall_a_ready", bus.a_ready, 1'b0);
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: got out_valid=1, want no result pending");
          end else begin
            e = sb.pop_front();
            if (e.m1) chk("outVec", MW'(bus.outVec), MW'(e.vec));
            else      chk("outMat", bus.outMat, e.mat);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      if (!bus.busy) ok = 1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy=1, want 0");
    end
  endtask

  // Issue one job; the model pushes expected results as beats are accepted.
  task automatic run_job(input bit m1, input bit pos, input int len, input logic [VW-1:0] accv,
                         input logic [SW*S-1:0] scol, input bit fixed,
                         input logic [16*A-1:0] fa, input logic [SW*A*S-1:0] fsm,
                         input logic [MW-1:0] fam, input bit exp_err);
    longint            acc [S];
    exp_t              e;
    logic [16*A-1:0]   av;
    logic [SW*A*S-1:0] smv;
    logic [MW-1:0]     amv;
    bit                ok;
    wait_idle();
    bus.isMatrixMul1 = m1;
    bus.isPos        = pos;
    bus.len          = 16'(len);
    bus.accVec       = accv;
    bus.sCol         = scol;
    bus.start        = 1;
    for (int j = 0; j < S; j++) acc[j] = longint'(accv[16*j +: 16]);
    e.m1 = m1;
    e.vec = '0;
    e.mat = '0;
    if (m1 && len == 0) begin
      for (int j = 0; j < S; j++) e.vec[16*j +: 16] = 16'(md(acc[j]));
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 0;
    if (len == 0) begin
      @(negedge clk);
      chk1("len0_busy", bus.busy, 1'b1);
      chk1("len0_valid", bus.out_valid, m1);
    end
    for (int b = 0; b < len; b++) begin
      av  = fixed ? fa  : rand_a();
      smv = fixed ? fsm : rand_smat();
      amv = fixed ? fam : rand_amat();
      bus.a = av;
      bus.sMat = smv;
      bus.accMat = amv;
      bus.a_valid = 0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      bus.a_valid = 1;
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
        @(negedge clk);
        if (bus.a_ready) begin
          ok = 1;
          if (m1) begin
            for (int j = 0; j < S; j++)
              for (int i = 0; i < A; i++)
                acc[j] += sval(smv[(j*A+i)*SW +: SW], pos) * longint'(av[16*i +: 16]);
            if (b == len - 1) begin
              for (int j = 0; j < S; j++) e.vec[16*j +: 16] = 16'(md(acc[j]));
              sb.push_back(e);
            end
          end else begin
            for (int j = 0; j < S; j++)
              for (int i = 0; i < A; i++)
                e.mat[16*(j*A+i) +: 16] = 16'(md(longint'(amv[16*(j*A+i) +: 16])
                  + sval(scol[SW*j +: SW], pos) * longint'(av[16*i +: 16])));
            sb.push_back(e);
          end
        end
        @(posedge clk);
        #1;
      end
      bus.a_valid = 0;
      if (!ok) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_timeout: a_ready=0 on beat %0d, want acceptance", b);
        return;
      end
    end
    wait_idle();
    chk("sb_drained", MW'(sb.size()), MW'(0));
    chk1("err", bus.err, exp_err);
  endtask

  initial begin
    logic [VW-1:0]     v;
    logic [SW*S-1:0]   sc;
    logic [SW*A*S-1:0] sm;
    logic [16*A-1:0]   av;
    logic [16*A-1:0]   row0;
    bit                ok;
    bit                e_err;

    rst = 1;
    bus.start = 0;
    bus.isMatrixMul1 = 0;
    bus.isPos = 0;
    bus.len = '0;
    bus.accVec = '0;
    bus.sCol = '0;
    bus.sMat = '0;
    bus.accMat = '0;
    bus.a = '0;
    bus.a_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_a_ready", bus.a_ready, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    chk("rst_outVec", MW'(bus.outVec), MW'(0));
    chk("rst_outMat", bus.outMat, MW'(0));
    rst = 0;
    rdy_rand = 1;

    // Mode1 add: accVec=1, all secrets +1, a=(1,2,3,4) twice -> 21 per row.
    for (int j = 0; j < S; j++) v[16*j +: 16] = 16'd1;
    for (int k = 0; k < A*S; k++) sm[k*SW +: SW] = SW'(2);
    for (int i = 0; i < A; i++) av[16*i +: 16] = 16'(i + 1);
    run_job(1, 1, 2, v, '0, 1, av, sm, '0, 0);

    // Mode1 subtract: magnitude 3, a=1 per lane -> -12 per row.
    for (int k = 0; k < A*S; k++) sm[k*SW +: SW] = SW'(6);
    for (int i = 0; i < A; i++) av[16*i +: 16] = 16'd1;
    run_job(1, 0, 1, '0, '0, 1, av, sm, '0, 0);

    // Mode2 with back-pressure: row0 secret -2, a=5 -> row0 holds -10 while stalled.
    sc = rand_scol();
    sc[SW-1:0] = SW'(5);
    for (int i = 0; i < A; i++) av[16*i +: 16] = 16'd5;
    for (int i = 0; i < A; i++) row0[16*i +: 16] = 16'(md(-10));
    rdy_rand = 0;
    rdy_force = 0;
    @(posedge clk);
    #1;
    fork
      run_job(0, 1, 3, '0, sc, 1, av, '0, '0, 0);
      begin
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
          @(negedge clk);
          if (bus.out_valid) ok = 1;
        end
        chk1("stall_first_valid", ok, 1'b1);
        repeat (3) begin
          @(negedge clk);
          chk1("stall_a_ready_dir", bus.a_ready, 1'b0);
          chk("stall_row0", MW'(bus.outMat[16*A-1:0]), MW'(row0));
        end
        rdy_force = 1;
      end
    join
    rdy_rand = 1;

    // len=0: DONE next cycle with outVec = accVec.
    run_job(1, 1, 0, rand_vec(), '0, 0, '0, '0, '0, 0);

    // Reset in the middle of a 4-beat mode1 job: no partial result.
    wait_idle();
    bus.isMatrixMul1 = 1;
    bus.isPos = 1;
    bus.len = 16'd4;
    bus.accVec = rand_vec();
    bus.start = 1;
    @(posedge clk);
    #1;
    bus.start = 0;
    bus.a = rand_a();
    bus.sMat = rand_smat();
    bus.a_valid = 1;
    @(posedge clk);
    #1;
    bus.a_valid = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_out_valid", bus.out_valid, 1'b0);
    chk1("midrst_a_ready", bus.a_ready, 1'b0);
    chk("midrst_outVec", MW'(bus.outVec), MW'(0));
    chk("midrst_outMat", bus.outMat, MW'(0));
    sb.delete();

    // Randomized jobs in both modes and both signs.
    for (int n = 0; n < 14; n++) begin
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 6),
              rand_vec(), rand_scol(), 0, '0, '0, '0, 0);
    end

    // Out-of-range secret magnitude (13 > SMAX) on an accepted mode1 beat.
`ifdef FRODO_MUL_SEQ_SCHECK_EN
    e_err = 1;
`else
    e_err = 0;
`endif
    sm = rand_smat();
    sm[SW-1:0] = SW'(26);
    run_job(1, 1, 1, rand_vec(), '0, 1, rand_a(), sm, '0, e_err);
    repeat (3) @(negedge clk);
    chk1("err_held", bus.err, e_err);
    // Next legal job clears it at start.
    run_job(0, 1, 2, '0, rand_scol(), 0, '0, '0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/frodo_mul_seq.md
FRODO_MUL_SEQ -- requirements
Module: frodo_mul_seq

Interface
REQ-001 SHALL have parameter A, default 4: number of a-lanes per beat.
REQ-002 SHALL have parameter S, default 8: number of rows.
REQ-003 SHALL have parameter SW, default 5: secret width; bit0 = sign, bits SW-1..1 = magnitude bits with weights 1,2,4,...
REQ-004 SHALL have parameter QB, default 16: modulus bits (15 or 16); results are reduced mod 2^QB.
REQ-005 SHALL have parameter SMAX, default 12: largest legal secret magnitude (used only under REQ-032).
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1: begin a job; sampled only in IDLE.
REQ-009 SHALL have port isMatrixMul1, input, 1: mode select, sampled at start; 1 = mode1 (vector accumulate), 0 = mode2 (matrix stream).
REQ-010 SHALL have port isPos, input, 1: add (1) or subtract (0), sampled at start.
REQ-011 SHALL have port len, input, 16: number of a-beats in the job, sampled at start.
REQ-012 SHALL have port accVec, input, 16*S: initial accumulator, mode1, sampled at start.
REQ-013 SHALL have port sCol, input, SW*S: secret column, mode2, sampled at start.
REQ-014 SHALL have port sMat, input, SW*A*S: secret matrix, mode1, sampled with each accepted beat.
REQ-015 SHALL have port accMat, input, 16*A*S: matrix addend, mode2, sampled with each accepted beat.
REQ-016 SHALL have ports a (input, 16*A: operand lanes), a_valid (input, 1) and a_ready (output, 1): the operand beat handshake.
REQ-017 SHALL have ports outVec (output, 16*S), outMat (output, 16*A*S), out_valid (output, 1) and out_ready (input, 1): the result handshake.
REQ-018 SHALL have ports busy (output, 1: not IDLE) and err (output, 1: sticky secret-range error).

Function
REQ-019 SHALL implement states IDLE, RUN and DONE, plus a 16-bit beat counter.
REQ-020 In IDLE, start=1 SHALL latch the mode, isPos, len, and accVec (mode1) or sCol (mode2), then go to RUN; with len=0 it SHALL go straight to DONE.
REQ-021 A beat SHALL be accepted only when a_valid & a_ready; each accepted beat SHALL increment the counter.
REQ-022 Per lane, the product SHALL be the magnitude times a, formed from shifted adds mod 2^16; it SHALL be negated when the sign bit XOR ~isPos is 1.
REQ-023 Mode1: a_ready=1 in RUN; each accepted beat SHALL apply state_j += sum over i of prod(sMat[j][i], a_i) for every row j.
REQ-024 Mode1: after beat len is accepted the block SHALL enter DONE, assert out_valid and drive outVec = state.
REQ-025 Mode1: in DONE, out_ready=1 SHALL return the block to IDLE in the same cycle's next state.
REQ-026 Mode2: a_ready = ~out_valid | out_ready, giving a one-entry output register.
REQ-027 Mode2: each accepted beat SHALL register outMat[j][i] = accMat[j][i] + prod(sCol_j, a_i) and set out_valid one cycle after acceptance.
REQ-028 Mode2: after the len-th beat is accepted, the block SHALL go to DONE and return to IDLE once that result is consumed.
REQ-029 Every output value SHALL have bits 15..QB forced to 0.
REQ-030 The following SHALL be ignored: start while busy; a_valid outside RUN; out_ready while out_valid=0. outVec and outMat SHALL hold their values while out_valid=1 and out_ready=0.

Reset
REQ-031 rst=1 at a clock edge SHALL, from any state including mid-job, force IDLE, counter=0, a_ready=0, out_valid=0, busy=0, err=0, and outVec, outMat and all state to 0; no partial result SHALL be emitted.

Configuration
REQ-032 With FRODO_MUL_SEQ_SCHECK_EN defined, err SHALL set when any used secret magnitude on an accepted beat or at start exceeds SMAX, and SHALL clear only on rst or the next start; without the macro, err SHALL be tied to 0 and no check logic SHALL exist.

Verification
REQ-033 Mode1, A=4, S=8, len=2, accVec=all 1, sMat all +1, a=(1,2,3,4) twice -> out_valid=1 after the 2nd beat, every outVec row = 21.
REQ-034 Mode1, isPos=0, len=1, accVec=0, sMat all magnitude 3 sign 0, a=(1,1,1,1) -> each row = 0xFFF4 (QB=16), or 0x7FF4 (QB=15).
REQ-035 Mode2, len=3, sCol row0=-2, accMat=0, a=(5,5,5,5), out_ready held 0 after the first result -> a_ready=0 and outMat row0 holds 0xFFF6 until out_ready=1, then 3 results total, then IDLE.
REQ-036 len=0 start -> DONE the next cycle, outVec = accVec.
REQ-037 rst pulsed after 1 of 4 beats -> next cycle IDLE, out_valid=0, outVec=0; a new job runs correctly.
REQ-038 With FRODO_MUL_SEQ_SCHECK_EN, a secret magnitude of 13 with SMAX=12 -> err=1, held until the next start; without the macro -> err stays 0.
